// File: rtl/dvi_rst_seq.sv
// dvi_rst_seq: reset/lock sequencer sitting behind the DVI PLL init controller.
// Restarts PLL init, waits for a stable lock, then releases the serializer and
// pixel-pipeline resets in order. Lock loss or lock timeout causes a bounded
// number of retries before a sticky failure state is entered.
`timescale 1ns/1ps

module dvi_rst_seq #(
    parameter int CLK_PERIOD   = 20,
    parameter int STABLE_TIME  = 100_000,
    parameter int TIMEOUT_TIME = 20_000_000,
    parameter int INIT_RST_CYC = 8,
    parameter int SER_HOLD_CYC = 16,
    parameter int RETRY_MAX    = 3
) (
    input  logic       I_CLK,
    input  logic       I_RST_N,
    input  logic       I_LOCK,
    input  logic       I_PLL_RST,
    output logic       O_INIT_RST,
    output logic       O_SER_RST,
    output logic       O_PIX_RST,
    output logic       O_READY,
    output logic       O_FAIL,
    output logic [3:0] O_RETRY_CNT
);

    localparam int STABLE_CNT  = (STABLE_TIME + CLK_PERIOD - 1) / CLK_PERIOD;
    localparam int TIMEOUT_CNT = (TIMEOUT_TIME + CLK_PERIOD - 1) / CLK_PERIOD;

    localparam int INIT_W    = $clog2(INIT_RST_CYC + 1);
    localparam int STABLE_W  = $clog2(STABLE_CNT + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CNT + 1);
    localparam int HOLD_W    = $clog2(SER_HOLD_CYC + 1);

    // The init and hold phases last one cycle longer than their count, since the
    // exit is taken on the edge after the counter has reached its threshold.
    // Stability and timeout are judged on the edge where the count would reach
    // its threshold, so they compare against threshold-1.
    localparam logic [INIT_W-1:0]    INIT_LAST    = INIT_W'(INIT_RST_CYC);
    localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(STABLE_CNT - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CNT - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST    = HOLD_W'(SER_HOLD_CYC);
    localparam logic [3:0]           RETRY_LIMIT  = 4'(RETRY_MAX);

    typedef enum logic [2:0] {
        ST_INIT_RST,
        ST_WAIT_LOCK,
        ST_SER_REL,
        ST_PIX_REL,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t                 r_state;
    logic [INIT_W-1:0]      r_initCnt;
    logic [STABLE_W-1:0]    r_stableCnt;
    logic [TIMEOUT_W-1:0]   r_timeoutCnt;
    logic [HOLD_W-1:0]      r_holdCnt;
    logic [3:0]             r_retryCnt;

    logic                   r_initRst;
    logic                   r_serRst;
    logic                   r_pixRst;
    logic                   r_ready;
    logic                   r_fail;

    state_t                 w_nextState;
    logic                   w_lockOk;
    logic                   w_failure;

    // Lock only counts toward stability while the PLL itself is out of reset.
    assign w_lockOk = I_LOCK & ~I_PLL_RST;

    // Output pattern {init, ser, pix, ready, fail} for a given state.
    function automatic logic [4:0] decodeOutputs(input state_t s);
        logic [4:0] v;
        v = 5'b11100;
        case (s)
            ST_INIT_RST:  v = 5'b11100;
            ST_WAIT_LOCK: v = 5'b01100;
            ST_SER_REL:   v = 5'b00100;
            ST_PIX_REL:   v = 5'b00000;
            ST_RUN:       v = 5'b00010;
            ST_FAIL:      v = 5'b01101;
            default:      v = 5'b11100;
        endcase
        return v;
    endfunction

    // Next-state decision; a failure overrides the state's normal exit and is
    // then routed either to a retry or to the sticky failure state.
    always_comb begin
        w_nextState = r_state;
        w_failure   = 1'b0;
        case (r_state)
            ST_INIT_RST: begin
                if (r_initCnt == INIT_LAST) begin
                    w_nextState = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lockOk && (r_stableCnt == STABLE_LAST)) begin
                    w_nextState = ST_SER_REL;
                end else if (r_timeoutCnt == TIMEOUT_LAST) begin
                    w_failure = 1'b1;
                end
            end
            ST_SER_REL: begin
                if (!I_LOCK) begin
                    w_failure = 1'b1;
                end else if (r_holdCnt == HOLD_LAST) begin
                    w_nextState = ST_PIX_REL;
                end
            end
            ST_PIX_REL: begin
                if (!I_LOCK) begin
                    w_failure = 1'b1;
                end else begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!I_LOCK) begin
                    w_failure = 1'b1;
                end
            end
            default: begin
                w_nextState = r_state;
            end
        endcase
        if (w_failure) begin
            w_nextState = (r_retryCnt == RETRY_LIMIT) ? ST_FAIL : ST_INIT_RST;
        end
    end

    // State, phase counters, retry count and registered outputs all advance together.
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            r_state      <= ST_INIT_RST;
            r_initCnt    <= '0;
            r_stableCnt  <= '0;
            r_timeoutCnt <= '0;
            r_holdCnt    <= '0;
            r_retryCnt   <= 4'd0;
            r_initRst    <= 1'b1;
            r_serRst     <= 1'b1;
            r_pixRst     <= 1'b1;
            r_ready      <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (w_nextState != r_state) begin
                r_initCnt    <= '0;
                r_stableCnt  <= '0;
                r_timeoutCnt <= '0;
                r_holdCnt    <= '0;
            end else begin
                case (r_state)
                    ST_INIT_RST: begin
                        r_initCnt <= r_initCnt + INIT_W'(1);
                    end
                    ST_WAIT_LOCK: begin
                        r_stableCnt  <= w_lockOk ? (r_stableCnt + STABLE_W'(1)) : '0;
                        r_timeoutCnt <= r_timeoutCnt + TIMEOUT_W'(1);
                    end
                    ST_SER_REL: begin
                        r_holdCnt <= r_holdCnt + HOLD_W'(1);
                    end
                    default: begin
                        r_initCnt <= r_initCnt;
                    end
                endcase
            end

            if (w_failure && (w_nextState == ST_INIT_RST)) begin
                r_retryCnt <= r_retryCnt + 4'd1;
            end else if ((w_nextState == ST_RUN) && (r_state != ST_RUN)) begin
                r_retryCnt <= 4'd0;
            end

            {r_initRst, r_serRst, r_pixRst, r_ready, r_fail} <= decodeOutputs(w_nextState);
        end
    end

    assign O_INIT_RST  = r_initRst;
    assign O_SER_RST   = r_serRst;
    assign O_PIX_RST   = r_pixRst;
    assign O_READY     = r_ready;
    assign O_FAIL      = r_fail;
    assign O_RETRY_CNT = r_retryCnt;

endmodule

// File: tb/tb_dvi_rst_seq.sv
// tb_dvi_rst_seq: scoreboard bench for dvi_rst_seq. A timeline model walks the
// stimulus phase by phase and records every expected output change; a monitor
// pops those events whenever the DUT outputs change.
`timescale 1ns/1ps

module tb_dvi_rst_seq;

    localparam int CLK_PERIOD   = 20;
    localparam int STABLE_TIME  = 200;
    localparam int TIMEOUT_TIME = 2000;
    localparam int INIT_C       = 4;
    localparam int SERH_C       = 8;
    localparam int RETRY_MAX    = 2;
    localparam int STABLE_C     = (STABLE_TIME + CLK_PERIOD - 1) / CLK_PERIOD;
    localparam int TIMEOUT_C    = (TIMEOUT_TIME + CLK_PERIOD - 1) / CLK_PERIOD;

    // {init, ser, pix, ready, fail}
    localparam logic [4:0] F_RST  = 5'b11100;
    localparam logic [4:0] F_INIT = 5'b11100;
    localparam logic [4:0] F_WAIT = 5'b01100;
    localparam logic [4:0] F_SER  = 5'b00100;
    localparam logic [4:0] F_PIX  = 5'b00000;
    localparam logic [4:0] F_RUN  = 5'b00010;
    localparam logic [4:0] F_FAIL = 5'b01101;

    logic       clk;
    logic       rstN;
    logic       lock;
    logic       pllRst;
    logic       oInitRst;
    logic       oSerRst;
    logic       oPixRst;
    logic       oReady;
    logic       oFail;
    logic [3:0] oRetryCnt;

    typedef struct {
        int         edgeNo;
        logic [8:0] vec;
    } event_t;

    bit         stimRst[$];
    bit         stimLock[$];
    bit         stimPll[$];
    logic [8:0] expOut[];
    event_t     sb[$];

    int  checks      = 0;
    int  errors      = 0;
    int  driveIdx    = -1;
    bit  monitorDone = 0;
    int  curRetry;
    int  stopAt;
    bit  stopIsReset;

    dvi_rst_seq #(
        .CLK_PERIOD   (CLK_PERIOD),
        .STABLE_TIME  (STABLE_TIME),
        .TIMEOUT_TIME (TIMEOUT_TIME),
        .INIT_RST_CYC (INIT_C),
        .SER_HOLD_CYC (SERH_C),
        .RETRY_MAX    (RETRY_MAX)
    ) dut (
        .I_CLK       (clk),
        .I_RST_N     (rstN),
        .I_LOCK      (lock),
        .I_PLL_RST   (pllRst),
        .O_INIT_RST  (oInitRst),
        .O_SER_RST   (oSerRst),
        .O_PIX_RST   (oPixRst),
        .O_READY     (oReady),
        .O_FAIL      (oFail),
        .O_RETRY_CNT (oRetryCnt)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD / 2) clk = ~clk;

    task automatic addEdges(input int n, input bit r, input bit l, input bit p);
        for (int i = 0; i < n; i++) begin
            stimRst.push_back(r);
            stimLock.push_back(l);
            stimPll.push_back(p);
        end
    endtask

    task automatic addRandom(input int n, input int dropPct);
        for (int i = 0; i < n; i++) begin
            stimRst.push_back($urandom_range(0, 399) != 0);
            stimLock.push_back($urandom_range(0, 99) >= dropPct);
            stimPll.push_back($urandom_range(0, 99) < 2);
        end
    endtask

    function automatic void setExp(input int e, input logic [4:0] f);
        expOut[e] = {f, 4'(curRetry)};
    endfunction

    // True when edge e is past the stimulus or is a reset edge; records which.
    function automatic bit halted(input int e);
        if (e >= stimRst.size()) begin
            stopIsReset = 0;
            stopAt      = e;
            return 1;
        end
        if (!stimRst[e]) begin
            curRetry    = 0;
            expOut[e]   = {F_RST, 4'd0};
            stopIsReset = 1;
            stopAt      = e;
            return 1;
        end
        return 0;
    endfunction

    function automatic int leave(output int nextStart);
        nextStart = stopAt;
        return stopIsReset ? 1 : 0;
    endfunction

    function automatic int failAt(input int e, output int nextStart);
        int t;
        nextStart = 0;
        if (curRetry == RETRY_MAX) begin
            setExp(e, F_FAIL);
            t = e;
            while (1) begin
                t++;
                if (halted(t)) return leave(nextStart);
                setExp(t, F_FAIL);
            end
        end
        curRetry++;
        setExp(e, F_INIT);
        nextStart = e;
        return 1;
    endfunction

    // One bring-up attempt whose init phase was entered at edge 'start'.
    // Returns 1 with nextStart set when a new attempt begins, 0 at end of stimulus.
    function automatic int runAttempt(input int start, output int nextStart);
        int e;
        int w;
        int s;
        int run;
        nextStart = 0;
        for (int k = 1; k <= INIT_C; k++) begin
            e = start + k;
            if (halted(e)) return leave(nextStart);
            setExp(e, F_INIT);
        end
        w = start + INIT_C + 1;
        if (halted(w)) return leave(nextStart);
        setExp(w, F_WAIT);
        run = 0;
        s   = w;
        for (int j = 1; j <= TIMEOUT_C; j++) begin
            e = w + j;
            if (halted(e)) return leave(nextStart);
            run = (stimLock[e] && !stimPll[e]) ? run + 1 : 0;
            if (run == STABLE_C) begin
                setExp(e, F_SER);
                s = e;
                break;
            end
            if (j == TIMEOUT_C) return failAt(e, nextStart);
            setExp(e, F_WAIT);
        end
        for (int j = 1; j <= SERH_C + 1; j++) begin
            e = s + j;
            if (halted(e)) return leave(nextStart);
            if (!stimLock[e]) return failAt(e, nextStart);
            setExp(e, (j == SERH_C + 1) ? F_PIX : F_SER);
        end
        e = s + SERH_C + 1;
        while (1) begin
            e++;
            if (halted(e)) return leave(nextStart);
            if (!stimLock[e]) return failAt(e, nextStart);
            curRetry = 0;
            setExp(e, F_RUN);
        end
        return 0;
    endfunction

    task automatic buildExpected();
        int start;
        int nxt;
        event_t ev;
        expOut   = new[stimRst.size()];
        curRetry = 0;
        expOut[0] = {F_RST, 4'd0};
        start = 0;
        while (runAttempt(start, nxt) != 0) begin
            start = nxt;
        end
        for (int e = 0; e < stimRst.size(); e++) begin
            if (e == 0 || expOut[e] != expOut[e-1]) begin
                ev.edgeNo = e;
                ev.vec    = expOut[e];
                sb.push_back(ev);
            end
        end
    endtask

    task automatic applyStimulus();
        for (int e = 0; e < stimRst.size(); e++) begin
            @(negedge clk);
            driveIdx = e;
            rstN     = stimRst[e];
            lock     = stimLock[e];
            pllRst   = stimPll[e];
        end
        @(negedge clk);
        monitorDone = 1;
    endtask

    task automatic checkOutput(input int e, input logic [8:0] got);
        event_t ev;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL outputs edge %0d got %b want no further change", e, got);
        end else begin
            ev = sb.pop_front();
            if (ev.edgeNo != e || ev.vec !== got) begin
                errors++;
                $display("[TB] FAIL outputs edge %0d got %b want %b at edge %0d",
                         e, got, ev.vec, ev.edgeNo);
            end
        end
    endtask

    // Monitor: any change of the output bundle is an observable DUT response.
    initial begin
        logic [8:0] prevV;
        logic [8:0] curV;
        bit         first;
        first = 1;
        prevV = '0;
        forever begin
            @(posedge clk);
            #1;
            if (driveIdx >= 0 && !monitorDone) begin
                curV = {oInitRst, oSerRst, oPixRst, oReady, oFail, oRetryCnt};
                if (first || curV !== prevV) begin
                    checkOutput(driveIdx, curV);
                    first = 0;
                    prevV = curV;
                end
            end
        end
    end

    initial begin
        rstN   = 1'b0;
        lock   = 1'b0;
        pllRst = 1'b0;

        // Clean bring-up, then a one-cycle lock loss in RUN and re-lock.
        addEdges(2, 0, 0, 0);
        addEdges(40, 1, 1, 0);
        addEdges(1, 1, 0, 0);
        addEdges(40, 1, 1, 0);

        // Glitchy lock during qualification.
        addEdges(2, 0, 0, 0);
        addEdges(5, 1, 0, 0);
        addEdges(7, 1, 1, 0);
        addEdges(1, 1, 0, 0);
        addEdges(35, 1, 1, 0);

        // Lock drop three cycles after serializer release, then recovery.
        addEdges(2, 0, 1, 0);
        addEdges(17, 1, 1, 0);
        addEdges(1, 1, 0, 0);
        addEdges(45, 1, 1, 0);

        // Reset during PIX_REL, then full bring-up again.
        addEdges(2, 0, 1, 0);
        addEdges(24, 1, 1, 0);
        addEdges(1, 0, 1, 0);
        addEdges(40, 1, 1, 0);

        // Repeated timeouts into FAIL, FAIL holds with lock, reset out of FAIL.
        addEdges(2, 0, 0, 0);
        addEdges(3 * (INIT_C + 1 + TIMEOUT_C) + 10, 1, 0, 0);
        addEdges(1000, 1, 1, 0);
        addEdges(1, 0, 1, 0);
        addEdges(40, 1, 1, 0);

        // Randomized lock/PLL/reset activity at several drop rates.
        addRandom(300, 1);
        addRandom(300, 3);
        addRandom(300, 8);
        addRandom(400, 40);
        addEdges(2, 0, 1, 0);
        addRandom(300, 2);

        buildExpected();
        applyStimulus();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending-events got %0d left want 0 (next at edge %0d)",
                     sb.size(), sb[0].edgeNo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvi_rst_seq.md
# dvi_rst_seq

Reset/lock sequencer directly downstream of the DVI PLL init controller, in the MDRP clock domain. It re-triggers PLL initialisation, qualifies the init controller's lock output for stability, then releases the serializer reset and the pixel-pipeline reset in order. On lock loss or lock timeout it retries a bounded number of times, then latches a failure flag.

## Interface
- CLK_PERIOD, 20: I_CLK period in ns.
- STABLE_TIME, 100_000: ns that lock must stay continuously high before the serializer is released; STABLE_CNT = ceil(STABLE_TIME/CLK_PERIOD).
- TIMEOUT_TIME, 20_000_000: maximum ns spent in WAIT_LOCK; TIMEOUT_CNT = ceil(TIMEOUT_TIME/CLK_PERIOD).
- INIT_RST_CYC, 8: cycles O_INIT_RST is held per attempt (≥1).
- SER_HOLD_CYC, 16: cycles between serializer release and pixel release (≥1).
- RETRY_MAX, 3: retries allowed before FAIL (0..15).

Ports:
- I_CLK, in, 1: MDRP clock, same clock as the PLL init controller.
- I_RST_N, in, 1: one clock; reset is synchronous and active-low.
- I_LOCK, in, 1: qualified lock from the PLL init controller (its O_LOCK).
- I_PLL_RST, in, 1: PLL reset from the PLL init controller (its O_RST), high = PLL held.
- O_INIT_RST, out, 1: drives the PLL init controller's I_RST, high = restart init.
- O_SER_RST, out, 1: serializer/clock-divider reset, active high.
- O_PIX_RST, out, 1: pixel-pipeline reset, active high.
- O_READY, out, 1: high in RUN.
- O_FAIL, out, 1: high in FAIL.
- O_RETRY_CNT, out, 4: consecutive-failure count.

## Operation
- States: INIT_RST, WAIT_LOCK, SER_REL, PIX_REL, RUN, FAIL.
- Outputs are registered Moore decodes of the next state, so each output changes on the same edge the state register does.
- Per-state outputs (INIT/SER/PIX/READY/FAIL):
  - INIT_RST 1/1/1/0/0
  - WAIT_LOCK 0/1/1/0/0
  - SER_REL 0/0/1/0/0
  - PIX_REL 0/0/0/0/0
  - RUN 0/0/0/1/0
  - FAIL 0/1/1/0/1
- INIT_RST: count INIT_RST_CYC cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - Stability counter increments on each cycle with I_LOCK=1 and I_PLL_RST=0. Any other cycle clears it.
  - When the counter reaches STABLE_CNT, go to SER_REL.
  - Timeout counter increments on every WAIT_LOCK cycle. Reaching TIMEOUT_CNT without stability is a failure.
  - If the stability and timeout conditions occur on the same cycle, stability wins.
- SER_REL: count SER_HOLD_CYC cycles, then go to PIX_REL.
- PIX_REL: one cycle, then go to RUN. Entering RUN clears the retry count.
- Failure sources:
  - WAIT_LOCK timeout.
  - I_LOCK=0 on any cycle in SER_REL, PIX_REL or RUN. This takes priority over that state's own transition.
- Failure handling:
  - If retry_cnt == RETRY_MAX, go to FAIL.
  - Otherwise increment retry_cnt and go to INIT_RST.
- All counters clear on every state entry.
- FAIL is absorbing; only I_RST_N exits it.
- Counter widths: $clog2(max+1) of each respective count; no wrap is possible because each counter stops at its threshold.

## Timing
- Reset (I_RST_N=0 at an edge) puts the block in INIT_RST with counters at 0.
- Output values during reset: O_INIT_RST=1, O_SER_RST=1, O_PIX_RST=1, O_READY=0, O_FAIL=0, O_RETRY_CNT=0.
- Reset mid-operation behaves identically from any state, including FAIL.
- O_INIT_RST is high for exactly INIT_RST_CYC edges after reset release, then falls.
- Lock qualification: with I_LOCK high continuously from WAIT_LOCK entry, O_SER_RST falls STABLE_CNT cycles after O_INIT_RST falls.
- O_PIX_RST falls exactly SER_HOLD_CYC+1 cycles after O_SER_RST falls.
- O_READY rises 1 cycle after O_PIX_RST falls.
- Lock drop while O_READY=1: on the edge after I_LOCK is sampled low, O_READY=0, O_SER_RST=1, O_PIX_RST=1 and O_INIT_RST=1, all on the same edge.
- O_RETRY_CNT updates on the same edge as the INIT_RST re-entry.
- No input is synchronised; all inputs are already in the I_CLK domain.

## Test plan
Parameters for all scenarios: CLK_PERIOD=20, STABLE_TIME=200 (10 cycles), TIMEOUT_TIME=2000 (100 cycles), INIT_RST_CYC=4, SER_HOLD_CYC=8, RETRY_MAX=2.

- Clean bring-up: release reset, hold I_LOCK=1 and I_PLL_RST=0.
  - Expect O_INIT_RST high for 4 cycles.
  - Expect O_SER_RST to fall 10 cycles later.
  - Expect O_PIX_RST to fall 9 cycles after that, and O_READY=1 one cycle later.
- Glitchy lock: I_LOCK high for 7 cycles, low for 1, then high.
  - Expect O_SER_RST to fall 10 cycles after the glitch ends, not earlier.
- Timeout retries: hold I_LOCK=0.
  - Expect O_INIT_RST pulses with O_RETRY_CNT going 1 then 2.
  - On the third timeout, expect O_FAIL=1 with O_SER_RST=1 and O_PIX_RST=1.
  - Expect FAIL to hold for 1000 cycles even with I_LOCK=1.
- Lock loss in RUN: reach RUN, then drop I_LOCK for 1 cycle.
  - Next edge: O_READY=0, all resets=1, O_RETRY_CNT=1.
  - Re-lock: expect RUN again with O_RETRY_CNT=0.
- Drop during SER_REL: drop I_LOCK 3 cycles after O_SER_RST falls.
  - Expect a retry, and O_PIX_RST never deasserts.
- Mid-sequence reset: assert I_RST_N=0 during PIX_REL and during FAIL.
  - Expect all outputs at reset values on the next edge.
  - Expect the full bring-up sequence to repeat.
